// File: rtl/bcd_to_bin_pkg.sv
// Shared definitions for the BCD-to-binary converter: digit width, largest
// legal digit, FSM state encoding and a digit validity helper.
package bcd_to_bin_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic {
        BCD2B_IDLE = 1'b0,
        BCD2B_CONV = 1'b1
    } bcd2b_state_e;

    // A BCD digit nibble above 9 (A..F) is not a legal decimal digit.
    function automatic logic bcd_digit_invalid(input logic [BCD_DIGIT_W-1:0] d);
        return (d > BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_to_bin_if.sv
// Start/busy/done handshake bundle between a requester (master) and the
// BCD-to-binary converter (slave).
interface bcd_to_bin_if
    import bcd_to_bin_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) ();

    logic                         start;
    logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in;
    logic                         busy;
    logic                         done;
    logic [BIN_W-1:0]             bin;
    logic                         err;

    modport master (
        output start,
        output bcd_in,
        input  busy,
        input  done,
        input  bin,
        input  err
    );

    modport slave (
        input  start,
        input  bcd_in,
        output busy,
        output done,
        output bin,
        output err
    );

endinterface

// File: rtl/bcd_to_bin_mac10.sv
// One Horner step of the decimal-to-binary conversion: acc*10 + digit,
// truncated to BIN_W bits, plus a flag for a non-decimal digit.
// Optional build macro BCD_TO_BIN_CLAMP_EN: when defined, digits above 9
// are replaced by 9 before accumulation; otherwise they are used raw.
module bcd_mac10
    import bcd_to_bin_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic [BIN_W-1:0]       acc,
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BIN_W-1:0]       acc_next,
    output logic                   invalid
);

    logic                   invalid_s;
    logic [BCD_DIGIT_W-1:0] digit_eff_s;

    // Classify the digit and choose the value that enters the accumulator.
    always_comb begin
        invalid_s   = bcd_digit_invalid(digit);
        digit_eff_s = digit;
`ifdef BCD_TO_BIN_CLAMP_EN
        if (invalid_s) begin
            digit_eff_s = BCD_MAX;
        end else begin
            digit_eff_s = digit;
        end
`else
        digit_eff_s = digit;
`endif
    end

    // acc*10 as two shifts and an add keeps the datapath multiplier-free.
    always_comb begin
        acc_next = (acc << 3) + (acc << 1) + BIN_W'(digit_eff_s);
        invalid  = invalid_s;
    end

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter, one digit per clock, MSD first.
// A start accepted in IDLE loads the packed BCD word; DIGITS clocks later
// done pulses with bin/err, which are then held until the next done.
// Optional build macro BCD_TO_BIN_CLAMP_EN (applied inside bcd_mac10).
module bcd_to_bin
    import bcd_to_bin_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic         clk,
    input  logic         reset_n,
    bcd_to_bin_if.slave  bus
);

    localparam int SR_W  = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    bcd2b_state_e      state_r, state_s;
    logic [SR_W-1:0]   shreg_r, shreg_s;
    logic [BIN_W-1:0]  acc_r, acc_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              err_flag_r, err_flag_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic [BIN_W-1:0]  bin_r, bin_s;
    logic              err_r, err_s;

    logic [BIN_W-1:0]  mac_acc_s;
    logic              mac_inv_s;

    bcd_mac10 #(
        .BIN_W (BIN_W)
    ) u_mac (
        .acc      (acc_r),
        .digit    (shreg_r[SR_W-1 -: BCD_DIGIT_W]),
        .acc_next (mac_acc_s),
        .invalid  (mac_inv_s)
    );

    // Next-state and datapath decisions; done defaults low so it is a pulse.
    always_comb begin
        state_s    = state_r;
        shreg_s    = shreg_r;
        acc_s      = acc_r;
        cnt_s      = cnt_r;
        err_flag_s = err_flag_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        bin_s      = bin_r;
        err_s      = err_r;

        case (state_r)
            BCD2B_IDLE: begin
                if (bus.start) begin
                    shreg_s    = bus.bcd_in;
                    acc_s      = {BIN_W{1'b0}};
                    cnt_s      = CNT_W'(DIGITS - 1);
                    err_flag_s = 1'b0;
                    busy_s     = 1'b1;
                    state_s    = BCD2B_CONV;
                end else begin
                    busy_s     = 1'b0;
                    state_s    = BCD2B_IDLE;
                end
            end

            BCD2B_CONV: begin
                acc_s   = mac_acc_s;
                shreg_s = shreg_r << BCD_DIGIT_W;
                if (mac_inv_s) begin
                    err_flag_s = 1'b1;
                end else begin
                    err_flag_s = err_flag_r;
                end
                if (cnt_r == {CNT_W{1'b0}}) begin
                    bin_s   = mac_acc_s;
                    err_s   = err_flag_r | mac_inv_s;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = BCD2B_IDLE;
                end else begin
                    cnt_s   = cnt_r - CNT_W'(1);
                    state_s = BCD2B_CONV;
                end
            end

            default: begin
                busy_s  = 1'b0;
                state_s = BCD2B_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= BCD2B_IDLE;
            shreg_r    <= {SR_W{1'b0}};
            acc_r      <= {BIN_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            err_flag_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            bin_r      <= {BIN_W{1'b0}};
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            shreg_r    <= shreg_s;
            acc_r      <= acc_s;
            cnt_r      <= cnt_s;
            err_flag_r <= err_flag_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            bin_r      <= bin_s;
            err_r      <= err_s;
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.bin  = bin_r;
    assign bus.err  = err_r;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: directed handshake cases plus random
// words checked against a positional-weight decimal model.
// Honours BCD_TO_BIN_CLAMP_EN in the reference model.
module tb_bcd_to_bin;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [31:0] last_bin = 32'd0;
    logic [31:0] last_err = 32'd0;

    bcd_to_bin_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

    bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Decimal value as sum of digit * 10^position, then modulo 2^BIN_W.
    function automatic void model(input logic [15:0] v, output logic [31:0] val, output logic [31:0] e);
        int sum;
        int w;
        int d;
        sum = 0;
        w   = 1;
        e   = 32'd0;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) begin
                e = 32'd1;
`ifdef BCD_TO_BIN_CLAMP_EN
                d = 9;
`endif
            end
            sum = sum + d * w;
            w   = w * 10;
        end
        val = 32'(sum % (1 << BIN_W));
    endfunction

    task automatic accept(input logic [15:0] v);
        bus.bcd_in = v;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        chk("busy_rise", 32'(bus.busy), 32'd1);
        chk("done_low_after_accept", 32'(bus.done), 32'd0);
    endtask

    task automatic finish(input logic [15:0] v, input bit noisy);
        logic [31:0] ev;
        logic [31:0] ee;
        model(v, ev, ee);
        for (int i = 1; i < DIGITS; i++) begin
            if (noisy && i < 3) begin
                bus.start  = 1'b1;
                bus.bcd_in = 16'h5555;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            chk("busy_hold", 32'(bus.busy), 32'd1);
            chk("no_early_done", 32'(bus.done), 32'd0);
            chk("bin_held", 32'(bus.bin), last_bin);
            chk("err_held", 32'(bus.err), last_err);
        end
        @(posedge clk);
        #1;
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("busy_fall", 32'(bus.busy), 32'd0);
        chk("bin_value", 32'(bus.bin), ev);
        chk("err_value", 32'(bus.err), ee);
        last_bin = ev;
        last_err = ee;
    endtask

    task automatic idle_check();
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(bus.done), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_bin_held", 32'(bus.bin), last_bin);
    endtask

    task automatic conv(input logic [15:0] v);
        accept(v);
        finish(v, 1'b0);
        idle_check();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] rv;
        bus.start  = 1'b0;
        bus.bcd_in = 16'h0000;

        // Reset and idle
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_bin", 32'(bus.bin), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) idle_check();

        // Directed conversions
        conv(16'h1234);
        chk("basic_1234", last_bin, 32'd1234);
        conv(16'h9999);
        chk("full_scale", last_bin, 32'd9999);
        conv(16'h0000);
        chk("zero", last_bin, 32'd0);
        conv(16'h12A4);
`ifdef BCD_TO_BIN_CLAMP_EN
        chk("invalid_bin", last_bin, 32'd1294);
`else
        chk("invalid_bin", last_bin, 32'd1304);
`endif
        chk("invalid_err", last_err, 32'd1);

        // start during busy is ignored, then back-to-back in the done cycle
        accept(16'h1234);
        finish(16'h1234, 1'b1);
        chk("ignored_starts", 32'(bus.bin), 32'd1234);
        accept(16'h0042);
        chk("b2b_bin_kept", 32'(bus.bin), 32'd1234);
        finish(16'h0042, 1'b0);
        chk("b2b_42", 32'(bus.bin), 32'd42);
        idle_check();

        // Reset mid-conversion aborts it
        accept(16'h9999);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_bin", 32'(bus.bin), 32'd0);
        last_bin = 32'd0;
        last_err = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < DIGITS + 2; i++) idle_check();
        conv(16'h0007);
        chk("after_abort_7", last_bin, 32'd7);

        // Random words, mostly legal digits with occasional A..F
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < DIGITS; i++) begin
                if ($urandom_range(0, 3) == 0) rv[4*i +: 4] = 4'($urandom_range(0, 15));
                else                            rv[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            conv(rv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
